// File: rtl/and16_serial_ctrl_pkg.sv
// rtl/and16_serial_ctrl_pkg.sv - shared FSM encoding and defaults for the serial AND controllers
package and16_serial_ctrl_pkg;

  localparam int STATE_W       = 2;
  localparam int DEFAULT_WIDTH = 16;

  // 2'b11 is unused and recovers to IDLE.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/and16_serial_ctrl_if.sv
// rtl/and16_serial_ctrl_if.sv - operand/result handshake bundle between requester and serial controller
interface and16_serial_ctrl_if
  import and16_serial_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out, busy
  );

endinterface

// File: rtl/and16_serial_ctrl_gate.sv
// rtl/and16_serial_ctrl_gate.sv - single two-input AND gate shared by the serial datapath
module and_gate (
  input  logic a,
  input  logic b,
  output logic out
);

  assign out = a & b;

endmodule

// File: rtl/and16_serial_ctrl.sv
// rtl/and16_serial_ctrl.sv - bit-serial WIDTH-bit AND through one shared gate, LSB first
module and16_serial_ctrl
  import and16_serial_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  and16_serial_ctrl_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] out_q;
  logic [CNT_W-1:0] cnt_q;
  logic             and_bit;

  and_gate u_and (
    .a   (sa_q[0]),
    .b   (sb_q[0]),
    .out (and_bit)
  );

  // Result bits enter at the MSB so the first (LSB) bit ends up at bit 0.
  assign acc_d = {and_bit, acc_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            sa_q    <= bus.a;
            sb_q    <= bus.b;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          acc_q <= acc_d;
          // Counter parks at WIDTH-1 on the final bit instead of wrapping.
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            out_q   <= acc_d;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.out       = out_q;

endmodule

// File: tb/tb_and16_serial_ctrl.sv
// tb/tb_and16_serial_ctrl.sv - scoreboard bench for and16_serial_ctrl at WIDTH=16 and WIDTH=5
module tb_and16_serial_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  logic [15:0] exp_q[$];
  logic [4:0]  exp5_q[$];

  and16_serial_ctrl_if #(.WIDTH(16)) bus ();
  and16_serial_ctrl_if #(.WIDTH(5))  bus5 ();

  and16_serial_ctrl #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  and16_serial_ctrl #(.WIDTH(5)) dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input logic [15:0] av, input logic [15:0] bv);
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    exp_q.push_back(av & bv);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_pop(input string name);
    logic [15:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got out=%h, required an expected entry but scoreboard empty", name, bus.out);
    end else begin
      e = exp_q.pop_front();
      if (bus.out !== e) begin
        n_fail++;
        $display("FAIL %s: got out=%h, required %h", name, bus.out, e);
      end
    end
  endtask

  task automatic test_reset;
    int n;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.out_ready = 1'b0;
    send(16'hF0F0, 16'hFFFF);
    wait_done(n);
    exp_q.delete();
    #3;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
    n_checks++;
    if (bus.out !== 16'h0000) begin n_fail++; $display("FAIL reset_out: got %h required 0000", bus.out); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic;
    int n;
    bus.out_ready = 1'b1;
    send(16'hFFFF, 16'h0F0F);
    n_checks++;
    if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b required 1", bus.busy); end
    wait_done(n);
    n_checks++;
    if (n != 16) begin n_fail++; $display("FAIL basic_latency: got %0d edges required 16", n); end
    check_pop("basic_out");
    // Hold in_valid through the DONE exit edge: it must not be taken.
    bus.in_valid = 1'b1;
    bus.a = 16'h1111;
    bus.b = 16'h1111;
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_exit: got out_valid=%b in_ready=%b busy=%b required 0,1,0", bus.out_valid, bus.in_ready, bus.busy);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_pattern;
    int n;
    bus.out_ready = 1'b1;
    send(16'hAAAA, 16'h5555);
    wait_done(n);
    check_pop("pattern_alt");
    @(posedge clk); #1;
    send(16'h8001, 16'h8001);
    wait_done(n);
    check_pop("pattern_ends");
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int n;
    logic [15:0] held;
    bus.out_ready = 1'b0;
    send(16'h3C5A, 16'hF00F);
    wait_done(n);
    held = bus.out;
    check_pop("bp_out");
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out !== held || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got out_valid=%b out=%h in_ready=%b required 1,%h,0", i, bus.out_valid, bus.out, bus.in_ready, held);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out !== held) begin
      n_fail++;
      $display("FAIL bp_release: got out_valid=%b in_ready=%b out=%h required 0,1,%h", bus.out_valid, bus.in_ready, bus.out, held);
    end
  endtask

  task automatic test_abort;
    int  n;
    bit  seen;
    bus.out_ready = 1'b1;
    send(16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_reset: got busy=%b out_valid=%b required 0,0", bus.busy, bus.out_valid);
    end
    #2;
    reset = 1'b0;
    exp_q.delete();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL abort_no_pulse: got out_valid pulse required none"); end
    send(16'h1234, 16'hFFFF);
    wait_done(n);
    check_pop("abort_next_op");
    @(posedge clk); #1;
  endtask

  task automatic test_stream;
    int sent;
    int got;
    int cyc;
    logic [15:0] e;
    sent = 0; got = 0; cyc = 0;
    exp_q.delete();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    while (got < 100 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(bus.a & bus.b);
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        got++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL stream_extra: got out=%h required no output", bus.out);
        end else begin
          e = exp_q.pop_front();
          if (bus.out !== e) begin n_fail++; $display("FAIL stream_data[%0d]: got %h required %h", got, bus.out, e); end
        end
      end
      @(posedge clk); #1;
      bus.in_valid  = (sent < 100) && ($urandom_range(0, 1) == 1);
      bus.a         = 16'($urandom);
      bus.b         = 16'($urandom);
      bus.out_ready = ($urandom_range(0, 1) == 1);
    end
    n_checks++;
    if (got != 100 || sent != 100 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_count: got %0d results from %0d sent, %0d pending, required 100/100/0", got, sent, exp_q.size());
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_stream_w5;
    int sent;
    int got;
    int cyc;
    logic [4:0] e;
    sent = 0; got = 0; cyc = 0;
    while (got < 40 && cyc < 10000) begin
      @(negedge clk);
      cyc++;
      if (bus5.in_valid && bus5.in_ready) begin
        exp5_q.push_back(bus5.a & bus5.b);
        sent++;
      end
      if (bus5.out_valid && bus5.out_ready) begin
        got++;
        n_checks++;
        if (exp5_q.size() == 0) begin
          n_fail++;
          $display("FAIL w5_extra: got out=%h required no output", bus5.out);
        end else begin
          e = exp5_q.pop_front();
          if (bus5.out !== e) begin n_fail++; $display("FAIL w5_data[%0d]: got %h required %h", got, bus5.out, e); end
        end
      end
      @(posedge clk); #1;
      bus5.in_valid  = (sent < 40) && ($urandom_range(0, 1) == 1);
      bus5.a         = 5'($urandom);
      bus5.b         = 5'($urandom);
      bus5.out_ready = ($urandom_range(0, 1) == 1);
    end
    n_checks++;
    if (got != 40 || exp5_q.size() != 0) begin
      n_fail++;
      $display("FAIL w5_count: got %0d results, %0d pending, required 40/0", got, exp5_q.size());
    end
    bus5.in_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;  bus.a = '0;  bus.b = '0;  bus.out_ready = 1'b0;
    bus5.in_valid = 1'b0; bus5.a = '0; bus5.b = '0; bus5.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_pattern();
    test_backpressure();
    test_abort();
    test_stream();
    test_stream_w5();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
